// File: rtl/multdiv_pkg.sv
// multdiv_pkg
//   Shared definitions for the iterative multiply/divide engine:
//   controller state encoding, default operand width and the
//   most-negative operand value used to detect divide overflow.
package multdiv_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [MD_WIDTH-1:0] MD_MOST_NEG = {1'b1, {(MD_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_if.sv
// multdiv_if
//   Start/operand/result bundle between the datapath and multdiv_unit.
//   master: drives ctrl_MULT, ctrl_DIV, data_operandA, data_operandB;
//           observes data_result, data_resultRDY, data_exception, busy.
//   slave : the engine side (multdiv_unit).
interface multdiv_if
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
);
    logic                 ctrl_MULT;
    logic                 ctrl_DIV;
    logic [WIDTH-1:0]     data_operandA;
    logic [WIDTH-1:0]     data_operandB;
    logic [2*WIDTH-1:0]   data_result;
    logic                 data_resultRDY;
    logic                 data_exception;
    logic                 busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_resultRDY, data_exception, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_resultRDY, data_exception, busy
    );
endinterface

// File: rtl/multdiv_divide_step.sv
// divide_step
//   One iteration of unsigned restoring division, purely combinational.
//   rem_in/quot_in : current partial remainder and dividend/quotient shift register
//   divisor        : divisor magnitude
//   rem_out/quot_out : values after shift, trial subtract and restore
module divide_step
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quot_out
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        // One extra bit keeps the sign of the trial result when the
        // divisor magnitude is 2^(WIDTH-1).
        shifted = {rem_in, quot_in[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[WIDTH]) begin
            rem_out  = shifted[WIDTH-1:0];
            quot_out = {quot_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out  = trial[WIDTH-1:0];
            quot_out = {quot_in[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit
//   Iterative signed WIDTHxWIDTH multiply (radix-2 Booth) and divide
//   (restoring, on magnitudes, truncating toward zero).
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : multdiv_if slave -- ctrl_MULT/ctrl_DIV start pulses, operands,
//             registered data_result ({rem, quot} for divide), one-cycle
//             data_resultRDY strobe, data_exception, busy.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic      clock,
    input  logic      reset_n,
    multdiv_if.slave  bus
);
    localparam int unsigned       CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]     LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state;
    logic [WIDTH-1:0]     a_q;
    logic [2*WIDTH:0]     acc;        // {upper, multiplier, booth bit}
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quot_q;
    logic [WIDTH-1:0]     dvsr_q;
    logic                 neg_quot_q;
    logic                 neg_rem_q;
    logic                 ovf_q;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   result_q;
    logic                 rdy_q;
    logic                 exc_q;
    logic                 busy_q;

    // Start decode
    logic                 accept;
    logic                 start_mult;
    logic                 start_div;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 b_zero;
    logic                 div_ovf;

    always_comb begin
        accept     = (state == IDLE) || (state == DONE);
        start_mult = accept && bus.ctrl_MULT;
        start_div  = accept && !bus.ctrl_MULT && bus.ctrl_DIV;
        a_mag      = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
        b_mag      = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
        b_zero     = (bus.data_operandB == '0);
        div_ovf    = (bus.data_operandA == MOST_NEG) && (bus.data_operandB == '1);
    end

    // Booth step: the sum is formed one bit wider so that adding or
    // subtracting the most-negative A cannot overflow before the shift.
    logic [WIDTH:0]       upper_ext;
    logic [WIDTH:0]       a_ext;
    logic [WIDTH:0]       booth_sum;
    logic [2*WIDTH:0]     acc_next;

    always_comb begin
        upper_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        a_ext     = {a_q[WIDTH-1], a_q};
        case (acc[1:0])
            2'b01:   booth_sum = upper_ext + a_ext;
            2'b10:   booth_sum = upper_ext - a_ext;
            default: booth_sum = upper_ext;
        endcase
        acc_next = {booth_sum, acc[WIDTH:1]};
    end

    // Division step and sign fixup
    logic [WIDTH-1:0]     rem_nx;
    logic [WIDTH-1:0]     quot_nx;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    divide_step #(.WIDTH(WIDTH)) u_divide_step (
        .rem_in   (rem_q),
        .quot_in  (quot_q),
        .divisor  (dvsr_q),
        .rem_out  (rem_nx),
        .quot_out (quot_nx)
    );

    always_comb begin
        quot_fix = neg_quot_q ? -quot_nx : quot_nx;
        rem_fix  = neg_rem_q  ? -rem_nx  : rem_nx;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            a_q        <= '0;
            acc        <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_q      <= 1'b0;
            cnt        <= '0;
            result_q   <= '0;
            rdy_q      <= 1'b0;
            exc_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_mult) begin
                        a_q    <= bus.data_operandA;
                        acc    <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
                        cnt    <= '0;
                        exc_q  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= MULT;
                    end else if (start_div) begin
                        a_q        <= bus.data_operandA;
                        rem_q      <= '0;
                        quot_q     <= a_mag;
                        dvsr_q     <= b_mag;
                        neg_quot_q <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                        neg_rem_q  <= bus.data_operandA[WIDTH-1];
                        ovf_q      <= div_ovf;
                        cnt        <= '0;
                        if (b_zero) begin
                            result_q <= '0;
                            exc_q    <= 1'b1;
                            rdy_q    <= 1'b1;
                            state    <= DONE;
                        end else begin
                            exc_q  <= 1'b0;
                            busy_q <= 1'b1;
                            state  <= DIV;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MULT: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        result_q <= acc_next[2*WIDTH:1];
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end
                end
                DIV: begin
                    rem_q  <= rem_nx;
                    quot_q <= quot_nx;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        result_q <= {rem_fix, quot_fix};
                        exc_q    <= ovf_q;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.data_exception = exc_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit
//   Directed vectors for multdiv_unit. Stimulus pushes the expected
//   result, exception flag and completion cycle into a queue; a monitor
//   on the falling edge pops and compares whenever data_resultRDY is high.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    typedef struct {
        string         name;
        logic [63:0]   res;
        logic          exc;
        int unsigned   due;
    } exp_t;

    logic        clock;
    logic        reset_n;
    int unsigned cyc;
    int unsigned total;
    int unsigned bad;
    exp_t        sb[$];

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Caller is at a falling edge; the next rising edge is cycle 0.
    task automatic drive(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic start_op(input string name, input logic m, input logic d,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] res, input logic exc, input int unsigned lat);
        exp_t e;
        e.name = name;
        e.res  = res;
        e.exc  = exc;
        e.due  = cyc + lat;
        sb.push_back(e);
        drive(m, d, a, b);
    endtask

    task automatic wait_drain(input string name, input int unsigned budget);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: %0d results outstanding after %0d cycles, required 0", name, sb.size(), budget);
            sb.delete();
        end
    endtask

    always @(negedge clock) begin
        if (bus.data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdy: strobe at cycle %0d with result %h, required no strobe", cyc, bus.data_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, bus.data_result, e.res);
                check({e.name, "_exc"}, 64'(bus.data_exception), 64'(e.exc));
                check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned busy_low;
        total = 0;
        bad   = 0;
        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(negedge clock);
        check("reset_result", bus.data_result, 64'h0);
        check("reset_rdy", 64'(bus.data_resultRDY), 64'h0);
        check("reset_exc", 64'(bus.data_exception), 64'h0);
        check("reset_busy", 64'(bus.busy), 64'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // 7 * -3, with busy profile over the iteration window
        start_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33);
        busy_low = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus.busy !== 1'b1) busy_low++;
            @(negedge clock);
        end
        check("busy_cycles_1_32_low_count", 64'(busy_low), 64'h0);
        check("busy_in_done", 64'(bus.busy), 64'h0);
        wait_drain("mul_7_m3", 10);

        start_op("mul_mneg_sq", 1'b1, 1'b0, MD_MOST_NEG, MD_MOST_NEG, 64'h4000_0000_0000_0000, 1'b0, 33);
        wait_drain("mul_mneg_sq", 60);
        start_op("mul_m1_m1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 33);
        wait_drain("mul_m1_m1", 60);

        start_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33);
        wait_drain("div_m7_2", 60);
        start_op("div_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 33);
        wait_drain("div_100_7", 60);
        start_op("div_7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 33);
        wait_drain("div_7_m2", 60);
        start_op("div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0, 64'h0, 1'b1, 1);
        wait_drain("div_by_zero", 10);
        start_op("div_overflow", 1'b0, 1'b1, MD_MOST_NEG, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, 33);
        wait_drain("div_overflow", 60);
        start_op("div_mneg_1", 1'b0, 1'b1, MD_MOST_NEG, 32'd1, 64'h0000_0000_8000_0000, 1'b0, 33);
        wait_drain("div_mneg_1", 60);

        // Both starts high: multiply wins (divide would give rem 1, quot -1)
        start_op("both_starts", 1'b1, 1'b1, 32'd6, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFE2, 1'b0, 33);
        wait_drain("both_starts", 60);

        // Abort: MULT, ignored DIV-by-zero pulse at cycle 10, reset at cycle 20
        drive(1'b1, 1'b0, 32'd3, 32'd3);
        repeat (9) @(negedge clock);
        drive(1'b0, 1'b1, 32'd9, 32'd0);
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("abort_result", bus.data_result, 64'h0);
        check("abort_rdy", 64'(bus.data_resultRDY), 64'h0);
        check("abort_exc", 64'(bus.data_exception), 64'h0);
        check("abort_busy", 64'(bus.busy), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        start_op("mul_after_reset", 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, 1'b0, 33);
        wait_drain("mul_after_reset", 60);
        @(negedge clock);

        // Back-to-back: second start pulsed in the DONE cycle of the first
        start_op("b2b_first", 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd100, 64'hFFFF_FFFF_FFFF_D8F0, 1'b0, 33);
        repeat (32) @(negedge clock);
        start_op("b2b_second", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE, 1'b0, 33);
        wait_drain("b2b", 60);
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative signed 32×32 multiply/divide engine for the processor datapath. Produces a 64-bit result that is written straight into the 64-bit product/quotient register (`register_64`).
- `data_resultRDY` drives that register's write enable; `data_result` drives its data input.
- One operation is in flight at a time, using a single-cycle start pulse and a one-cycle completion strobe.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the result is 2*WIDTH bits.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ctrl_MULT`  in  1  start a signed multiply; sampled only when accepting.
- `ctrl_DIV`  in  1  start a signed divide; sampled only when accepting.
- `data_operandA`  in  WIDTH  multiplicand / dividend; latched at start.
- `data_operandB`  in  WIDTH  multiplier / divisor; latched at start.
- `data_result`  out  2*WIDTH  multiply: full signed product; divide: {remainder, quotient}. Remainder is in the upper WIDTH bits.
- `data_resultRDY`  out  1  one-cycle strobe; `data_result` and `data_exception` are valid in this cycle.
- `data_exception`  out  1  divide by zero, or divide overflow (most-negative / -1).
- `busy`  out  1  high while iterating; starts are ignored while high.

## Operation
- States: IDLE, MULT, DIV, DONE. The start is accepted in IDLE or DONE, so back-to-back operations are allowed.
- Start arbitration:
  - `ctrl_MULT` has priority over `ctrl_DIV` if both are high.
  - A start pulse while `busy` is ignored and has no effect.
- At start:
  - Latch both operands.
  - Clear the iteration counter (`$clog2(WIDTH)` bits).
  - Clear `data_exception`.
- MULT: radix-2 Booth recoding.
  - Accumulator is {WIDTH-bit upper, WIDTH-bit multiplier, 1-bit Booth bit}.
  - Each cycle: add or subtract the latched A per the bit pair, then arithmetic-shift right by 1.
  - Exactly WIDTH iterations, then DONE.
- DIV: restoring division on magnitudes.
  - Take |A| and |B| as WIDTH-bit unsigned; the magnitude of the most-negative value is 2^(WIDTH-1).
  - Each cycle: shift the {rem, quot} pair left, trial-subtract |B|, and restore on negative.
  - Exactly WIDTH iterations, then DONE.
- DIV sign fixup in the transition to DONE (truncation toward zero):
  - Quotient is negated if sign(A) XOR sign(B).
  - Remainder takes sign(A).
- Divide by zero:
  - No iterations; go IDLE→DONE directly.
  - `data_result` = 0, `data_exception` = 1.
- Divide overflow (A = 0x8000_0000, B = -1):
  - Iterate normally.
  - Quotient wraps to 0x8000_0000, remainder = 0, `data_exception` = 1.
- DONE:
  - `data_result` is registered on entry.
  - `data_resultRDY` = 1 for this single cycle.
  - Next state is IDLE, or MULT/DIV if a new start is accepted in DONE.
- `data_result` and `data_exception` hold until the next completion.
- Reset (`reset_n` low, any time, including mid-operation):
  - State → IDLE.
  - All outputs and internal registers are 0.
  - No `data_resultRDY` is produced for the aborted operation.

## Timing
- Cycle 0 = the rising edge that samples the start.
- MULT/DIV latency is WIDTH+1 cycles: `data_resultRDY` is high in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- Divide by zero latency is 1 cycle: `data_resultRDY` is high in cycle 1.
- `busy` is high in cycles 1..WIDTH and low in DONE and IDLE.
- Maximum throughput is one operation per WIDTH+1 cycles, achieved by restarting in DONE.
- Operand inputs may change freely after cycle 0.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package `multdiv_pkg` holds:
  - the state enum (IDLE, MULT, DIV, DONE);
  - the default WIDTH;
  - the most-negative-value constant used for overflow detection.
- One sub-module, `divide_step`: combinational shift / trial-subtract / restore for one division iteration, instantiated once.
- Booth add/shift and the controller stay in `multdiv_unit`.

## Test plan
- MULT A=7, B=-3 → `data_result` = 0xFFFF_FFFF_FFFF_FFEB. `data_resultRDY` only in cycle 33; `busy` high in cycles 1–32; `data_exception` = 0.
- MULT A=0x8000_0000, B=0x8000_0000 → 0x4000_0000_0000_0000. MULT A=0xFFFF_FFFF, B=0xFFFF_FFFF → 0x0000_0000_0000_0001.
- DIV A=-7, B=2 → `data_result` = 0xFFFF_FFFF_FFFF_FFFD (rem -1, quot -3). DIV A=100, B=7 → 0x0000_0002_0000_000E.
- DIV A=5, B=0 → `data_resultRDY` in cycle 1, `data_result` = 0, `data_exception` = 1. DIV A=0x8000_0000, B=-1 → `data_result` = 0x0000_0000_8000_0000, `data_exception` = 1.
- Start MULT, pulse `ctrl_DIV` at cycle 10, then assert `reset_n` low at cycle 20 → the DIV pulse is ignored; after reset all outputs are 0 and no `data_resultRDY` occurs. A new MULT afterwards completes normally.
- Back-to-back: second MULT pulsed in the DONE cycle → second `data_resultRDY` exactly 33 cycles after the first. Both `ctrl_MULT` and `ctrl_DIV` high at start → multiply result.
